// File: rtl/isp_bus_pkg.sv
// Shared constants, the arbiter state type and a small round-robin helper
// for the frame-memory bus.
package isp_bus_pkg;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 32;
  localparam int FRAME_W      = 320;
  localparam int FRAME_H      = 240;
  localparam int PAD_IN_BYTES = (322 * 242);
  localparam int OUT_BYTES    = (FRAME_W * FRAME_H);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RECOVER
  } bus_arb_state_t;

  // Next round-robin position after client idx, wrapping at n.
  function automatic int rr_wrap_inc(input int idx, input int n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotating-priority pick: the first requester at or after
// ptr (wrapping) wins. Requests are rotated so ptr lands on bit 0, a plain
// lowest-bit-first priority chain selects, and the grant is rotated back.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [N-1:0] rot_req;
  logic [N-1:0] rot_gnt;
  logic [N:0]   seen;

  // Bit i of rot_req is client (ptr + i) mod N.
  assign rot_req = N'({req, req} >> ptr);

  // seen[i] is set when any rotated request below bit i is active.
  assign seen[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_prio
      assign rot_gnt[gi]  = rot_req[gi] & ~seen[gi];
      assign seen[gi + 1] = seen[gi] | rot_req[gi];
    end
  endgenerate

  // Undo the rotation: the upper half of the doubled, left-shifted grant
  // holds the grant in client order.
  assign gnt   = N'(({rot_gnt, rot_gnt} << ptr) >> N);
  assign valid = seen[N];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares the single frame-memory bus master port
// among NUM_CLIENTS requesters. Each client uses a req/done (or err)
// handshake; the arbiter runs the bus write/read handshake itself and a
// watchdog aborts transactions that never complete.
module bus_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W      = isp_bus_pkg::ADDR_W,
  parameter int DATA_W      = isp_bus_pkg::DATA_W,
  parameter int TIMEOUT     = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CLIENTS-1:0]        c_req,
  input  logic [NUM_CLIENTS-1:0]        c_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] c_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] c_wdata,
  output logic [NUM_CLIENTS-1:0]        c_gnt,
  output logic [NUM_CLIENTS-1:0]        c_done,
  output logic [NUM_CLIENTS-1:0]        c_err,
  output logic [DATA_W-1:0]             c_rdata,
  output logic                          write,
  output logic [ADDR_W-1:0]             write_addr,
  output logic [DATA_W-1:0]             iData,
  input  logic                          write_done,
  output logic                          read,
  output logic [ADDR_W-1:0]             read_addr,
  input  logic [DATA_W-1:0]             oData,
  input  logic                          oValid,
  input  logic                          read_done
);

  import isp_bus_pkg::*;

  localparam int PTR_W = $clog2(NUM_CLIENTS);
  // TIMEOUT == 0 disables the watchdog; keep the counter 1 bit wide then.
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [NUM_CLIENTS-1:0] ONE_HOT0 = NUM_CLIENTS'(1);

  bus_arb_state_t state_reg, state_next;
  logic [PTR_W-1:0]       ptr_reg, ptr_next;
  logic [PTR_W-1:0]       idx_reg, idx_next;
  logic [ADDR_W-1:0]      addr_reg, addr_next;
  logic [DATA_W-1:0]      wdata_reg, wdata_next;
  logic [DATA_W-1:0]      rdata_reg, rdata_next;
  logic [WD_W-1:0]        wd_cnt_reg, wd_cnt_next;
  logic [NUM_CLIENTS-1:0] done_reg, done_next;
  logic [NUM_CLIENTS-1:0] err_reg, err_next;

  logic [NUM_CLIENTS-1:0] pick_gnt;
  logic                   pick_valid;
  logic [PTR_W-1:0]       pick_idx;
  logic                   wd_expire;

  // read_done is informational only; sequencing relies on oValid.
  logic unused_read_done;
  assign unused_read_done = read_done;

  logic [ADDR_W-1:0] addr_arr  [NUM_CLIENTS];
  logic [DATA_W-1:0] wdata_arr [NUM_CLIENTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = c_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = c_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .N     (NUM_CLIENTS),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (c_req),
    .ptr   (ptr_reg),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // One-hot pick to client index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_gnt[i]) pick_idx = PTR_W'(i);
    end
  end

  assign wd_expire = WD_EN && (wd_cnt_reg == WD_LAST);

  // Next-state, capture and watchdog logic; completion has priority over timeout.
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    idx_next    = idx_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    wd_cnt_next = wd_cnt_reg;
    done_next   = '0;
    err_next    = '0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          idx_next    = pick_idx;
          addr_next   = addr_arr[pick_idx];
          wdata_next  = wdata_arr[pick_idx];
          wd_cnt_next = '0;
          state_next  = c_we[pick_idx] ? WRITE : READ;
        end
      end
      WRITE: begin
        if (write_done) begin
          done_next[idx_reg] = 1'b1;
          state_next         = RECOVER;
        end else if (wd_expire) begin
          err_next[idx_reg] = 1'b1;
          state_next        = RECOVER;
        end else begin
          wd_cnt_next = wd_cnt_reg + WD_W'(1);
        end
      end
      READ: begin
        if (oValid) begin
          rdata_next         = oData;
          done_next[idx_reg] = 1'b1;
          state_next         = RECOVER;
        end else if (wd_expire) begin
          err_next[idx_reg] = 1'b1;
          state_next        = RECOVER;
        end else begin
          wd_cnt_next = wd_cnt_reg + WD_W'(1);
        end
      end
      RECOVER: begin
        ptr_next   = PTR_W'(rr_wrap_inc(int'(idx_reg), NUM_CLIENTS));
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything so the bus drops at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      idx_reg    <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      wd_cnt_reg <= '0;
      done_reg   <= '0;
      err_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      idx_reg    <= idx_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      wd_cnt_reg <= wd_cnt_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  assign write      = (state_reg == WRITE);
  assign read       = (state_reg == READ);
  assign write_addr = addr_reg;
  assign read_addr  = addr_reg;
  assign iData      = wdata_reg;
  assign c_gnt      = (write || read) ? (ONE_HOT0 << idx_reg) : '0;
  assign c_done     = done_reg;
  assign c_err      = err_reg;
  assign c_rdata    = rdata_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a table of single-client transactions
// plus hand-written sequences for reset, tie-break and fairness.
module tb_bus_arbiter;

  localparam int N       = 3;
  localparam int AW      = 19;
  localparam int DW      = 32;
  localparam int TO      = 16;
  localparam int BUS_DLY = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    c_req, c_we, c_gnt, c_done, c_err;
  logic [N*AW-1:0] c_addr;
  logic [N*DW-1:0] c_wdata;
  logic [DW-1:0]   c_rdata, iData, oData;
  logic [AW-1:0]   write_addr, read_addr;
  logic            write, write_done, read, oValid, read_done;

  int n_applied = 0;
  int n_miss    = 0;
  bit bus_hang  = 1'b0;

  logic [DW-1:0] mem [logic [AW-1:0]];

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_CLIENTS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .c_req      (c_req),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_wdata    (c_wdata),
    .c_gnt      (c_gnt),
    .c_done     (c_done),
    .c_err      (c_err),
    .c_rdata    (c_rdata),
    .write      (write),
    .write_addr (write_addr),
    .iData      (iData),
    .write_done (write_done),
    .read       (read),
    .read_addr  (read_addr),
    .oData      (oData),
    .oValid     (oValid),
    .read_done  (read_done)
  );

  // Bus slave: completes each access BUS_DLY cycles after the request rises.
  initial begin
    int wcnt;
    int rcnt;
    wcnt = 0;
    rcnt = 0;
    write_done = 1'b0;
    oValid     = 1'b0;
    read_done  = 1'b0;
    oData      = '0;
    forever begin
      @(posedge clk);
      #1;
      write_done = 1'b0;
      oValid     = 1'b0;
      read_done  = 1'b0;
      oData      = 32'hDEAD_BEEF;
      if (write && !bus_hang) begin
        wcnt++;
        if (wcnt == BUS_DLY) begin
          write_done      = 1'b1;
          mem[write_addr] = iData;
        end
      end else begin
        wcnt = 0;
      end
      if (read && !bus_hang) begin
        rcnt++;
        if (rcnt == BUS_DLY) begin
          oValid    = 1'b1;
          read_done = 1'b1;
          oData     = mem.exists(read_addr) ? mem[read_addr] : DW'(read_addr);
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1, "simulation time limit");
  end

  typedef struct {
    int            client;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            hang;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] one;
    one = 1;
    return one << k;
  endfunction

  function automatic logic [127:0] outs();
    return {c_gnt, c_done, c_err, c_rdata, write, write_addr, iData, read, read_addr};
  endfunction

  task automatic drive(input int c, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_we[c]             = we;
    c_addr[c*AW +: AW]  = a;
    c_wdata[c*DW +: DW] = d;
  endtask

  // Single-client transaction from IDLE, checked at grant, during hold and at completion.
  task automatic run_vec(input vec_t v, input int num);
    int           cyc;
    bit           stable;
    logic [N-1:0] oh;
    oh       = onehot(v.client);
    bus_hang = v.hang;
    drive(v.client, v.we, v.addr, v.wdata);
    c_req[v.client] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (c_gnt == '0 && cyc < 32);
    chk("grant_latency", cyc, 1);
    chk("grant_onehot", c_gnt, oh);
    chk("bus_dir", {write, read}, {v.we, !v.we});
    chk("bus_addr", v.we ? write_addr : read_addr, v.addr);
    if (v.we) chk("bus_wdata", iData, v.wdata);
    // Captured at grant: the client is free to change its inputs now.
    drive(v.client, !v.we, ~v.addr, ~v.wdata);
    stable = 1'b1;
    cyc    = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (c_done == '0 && c_err == '0) begin
        if (c_gnt !== oh) stable = 1'b0;
        if (v.we && (!write || read || write_addr !== v.addr || iData !== v.wdata)) stable = 1'b0;
        if (!v.we && (!read || write || read_addr !== v.addr)) stable = 1'b0;
      end
    end while (c_done == '0 && c_err == '0 && cyc < 64);
    chk("hold_stable", stable, 1);
    chk("bus_cycles", cyc, v.hang ? TO : BUS_DLY);
    chk("done_pulse", c_done, v.hang ? '0 : oh);
    chk("err_pulse", c_err, v.hang ? oh : '0);
    chk("recover_idle", {write, read, c_gnt}, '0);
    if (!v.we && !v.hang) chk("rdata", c_rdata, v.exp_rdata);
    $display("txn %0d: client %0d %s addr=%0d data=0x%0h -> %s after %0d cycles, rdata=0x%0h",
             num, v.client, v.we ? "write" : "read", v.addr, v.wdata,
             (c_err != '0) ? "err" : "done", cyc, c_rdata);
    c_req[v.client] = 1'b0;
    bus_hang        = 1'b0;
    @(posedge clk);
    #1;
    chk("pulse_width", {c_done, c_err}, '0);
  endtask

  // Several clients hold req; grants must follow the expected order with a gap between.
  task automatic run_seq(input logic [N-1:0] mask, input int order[6], input int n, input string tag);
    int cyc;
    for (int c = 0; c < N; c++) drive(c, 1'b1, AW'(100 + c), DW'(32'hC0 + c));
    c_req = mask;
    for (int t = 0; t < n; t++) begin
      cyc = 0;
      do begin
        @(posedge clk);
        #1;
        cyc++;
      end while (c_gnt == '0 && cyc < 32);
      chk($sformatf("%s_grant%0d", tag, t), c_gnt, onehot(order[t]));
      cyc = 0;
      do begin
        @(posedge clk);
        #1;
        cyc++;
      end while (c_done == '0 && c_err == '0 && cyc < 64);
      chk($sformatf("%s_done%0d", tag, t), c_done, onehot(order[t]));
      chk($sformatf("%s_gap%0d", tag, t), {write, read, c_gnt}, '0);
      $display("txn %s[%0d]: req=%b served client %0d, done=%b", tag, t, mask, order[t], c_done);
    end
    c_req = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int k;
    reset_n = 1'b0;
    c_req   = '0;
    c_we    = '0;
    c_addr  = '0;
    c_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_reset", outs(), '0);

    // Vector table: single write, single read, timeout, follow-up, then the sweep
    vecs.push_back('{client: 0, we: 1'b1, addr: 4,  wdata: 4,            hang: 1'b0, exp_rdata: 0});
    vecs.push_back('{client: 1, we: 1'b0, addr: 8,  wdata: 0,            hang: 1'b0, exp_rdata: 8});
    vecs.push_back('{client: 0, we: 1'b1, addr: 12, wdata: 32'h1234_5678, hang: 1'b1, exp_rdata: 0});
    vecs.push_back('{client: 2, we: 1'b0, addr: 12, wdata: 0,            hang: 1'b0, exp_rdata: 12});
    for (int a = 4; a <= 64; a += 4)
      vecs.push_back('{client: (a / 4) % N, we: 1'b1, addr: AW'(a), wdata: DW'(a), hang: 1'b0, exp_rdata: 0});
    for (int a = 4; a <= 64; a += 4)
      vecs.push_back('{client: (a / 4 + 1) % N, we: 1'b0, addr: AW'(a), wdata: 0, hang: 1'b0, exp_rdata: DW'(a)});
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset asserted mid-read drops the bus immediately
    k = 1;
    drive(k, 1'b0, 20, 0);
    c_req[k] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!read && cyc < 16);
    chk("t5_read_up", read, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_async_reset", outs(), '0);
    c_req = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("t5_held_reset", outs(), '0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_quiet_after_release", outs(), '0);

    // Tie between clients 0 and 2 after reset, then full three-way fairness
    run_seq(3'b101, '{0, 2, 0, 0, 0, 0}, 2, "t5");
    run_seq(3'b111, '{0, 1, 2, 0, 1, 2}, 6, "t3");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
